// File: rtl/irq_request_latch_pkg.sv
// Shared constants and FSM state type for the interrupt request latch.
package irq_request_latch_pkg;

    localparam int unsigned IRQ_N           = 16;  // request lines
    localparam int unsigned IRQ_CODE_W      = 4;   // clog2(IRQ_N)
    localparam int unsigned IRQ_SYNC_STAGES = 2;   // synchroniser depth, >= 2

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

endpackage : irq_request_latch_pkg

// File: rtl/irq_request_latch_prio_enc.sv
// Priority encoder: lowest set index of the eligible set wins.
// Ports:
//   eligible  in   N       candidate request bits
//   code_c    out  CODE_W  index of the lowest set bit (0 when none)
//   active_c  out  1       at least one bit set
module irq_request_latch_prio_enc #(
    parameter int unsigned N      = 16,
    parameter int unsigned CODE_W = 4
) (
    input  logic [N-1:0]      eligible,
    output logic [CODE_W-1:0] code_c,
    output logic              active_c
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        code_c   = '0;
        active_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                code_c   = CODE_W'(i);
                active_c = 1'b1;
            end
        end
    end

endmodule : irq_request_latch_prio_enc

// File: rtl/irq_request_latch.sv
// Synchronises asynchronous request lines, latches their rising edges into a
// sticky pending register and offers the lowest unmasked pending index over a
// valid/ready handshake, clearing that bit when it is accepted.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req          asynchronous level request lines
//   mask         1 = keep pending but do not offer
//   sw_clear     synchronous clear of all pending bits (also cancels an offer)
//   out_valid    index offered
//   out_code     offered index, held for the whole offer
//   out_ready    downstream accepts when out_valid && out_ready
//   pending      raw pending register
//   any_pending  registered |(pending & ~mask)
module irq_request_latch
    import irq_request_latch_pkg::*;
#(
    parameter int unsigned N           = IRQ_N,
    parameter int unsigned CODE_W      = IRQ_CODE_W,
    parameter int unsigned SYNC_STAGES = IRQ_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      mask,
    input  logic              sw_clear,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    input  logic              out_ready,
    output logic [N-1:0]      pending,
    output logic              any_pending
);

    state_e              state, state_nxt;
    logic [N-1:0]        sync_last;
    logic [N-1:0]        prev;
    logic [N-1:0]        rise;
    logic [N-1:0]        clr;
    logic [N-1:0]        pending_nxt;
    logic [N-1:0]        eligible;
    logic [CODE_W-1:0]   win_code;
    logic                win_act;
    logic                valid_nxt;
    logic [CODE_W-1:0]   code_nxt;

    // Input synchroniser, one flop rank per stage.
    for (genvar s = 0; s < int'(SYNC_STAGES); s++) begin : g_sync
        logic [N-1:0] q;
        if (s == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q <= '0;
                else     q <= req;
            end
        end else begin : g_next
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q <= '0;
                else     q <= g_sync[s-1].q;
            end
        end
    end

    assign sync_last = g_sync[SYNC_STAGES-1].q;

    // Rising-edge detect: a held level produces a single event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '0;
        else     prev <= sync_last;
    end

    assign rise     = sync_last & ~prev;
    assign eligible = pending & ~mask;

    irq_request_latch_prio_enc #(
        .N      (N),
        .CODE_W (CODE_W)
    ) u_enc (
        .eligible (eligible),
        .code_c   (win_code),
        .active_c (win_act)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_code    <= '0;
            pending     <= '0;
            any_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_valid   <= valid_nxt;
            out_code    <= code_nxt;
            pending     <= pending_nxt;
            any_pending <= |(pending_nxt & ~mask);
        end
    end

    // Next state, offer control and pending update. A new rise beats a clear.
    always_comb begin
        state_nxt = state;
        valid_nxt = out_valid;
        code_nxt  = out_code;
        clr       = {N{sw_clear}};
        case (state)
            IDLE: begin
                if (win_act && !sw_clear) begin
                    code_nxt  = win_code;
                    valid_nxt = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (sw_clear) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    clr       = N'(1) << out_code;
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
        pending_nxt = (pending & ~clr) | rise;
    end

endmodule : irq_request_latch

// File: tb/tb_irq_request_latch.sv
// Bench for irq_request_latch: single-request vector table plus hand-written
// multi-cycle sequences; accepted indices are checked against a queue of
// expected codes.
module tb_irq_request_latch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] mask = '0;
    logic        sw_clear = 1'b0;
    logic        out_valid;
    logic [3:0]  out_code;
    logic        out_ready = 1'b0;
    logic [15:0] pending;
    logic        any_pending;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        int   idx;
        logic msk;
        logic exp_valid;
        logic exp_any;
    } vec_t;

    vec_t vecs[5];

    irq_request_latch dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mask        (mask),
        .sw_clear    (sw_clear),
        .out_valid   (out_valid),
        .out_code    (out_code),
        .out_ready   (out_ready),
        .pending     (pending),
        .any_pending (any_pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int max, input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain(input int max, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every accepted index must be the next expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !sw_clear) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL accept: got unexpected code %0d", out_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (out_code !== e) begin
                    bad++;
                    $display("FAIL accept: got code %0d want %0d", out_code, e);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{idx: 0,  msk: 1'b0, exp_valid: 1'b1, exp_any: 1'b1};
        vecs[1] = '{idx: 15, msk: 1'b0, exp_valid: 1'b1, exp_any: 1'b1};
        vecs[2] = '{idx: 7,  msk: 1'b1, exp_valid: 1'b0, exp_any: 1'b0};
        vecs[3] = '{idx: 10, msk: 1'b0, exp_valid: 1'b1, exp_any: 1'b1};
        vecs[4] = '{idx: 1,  msk: 1'b1, exp_valid: 1'b0, exp_any: 1'b0};

        // Reset
        #1 rst = 1'b1;
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_any", 32'(any_pending), 32'd0);
        rst = 1'b0;
        step();

        // Table: single request, optionally masked, no acceptance
        foreach (vecs[k]) begin
            logic [15:0] bit_v;
            bit_v = 16'(1) << vecs[k].idx;
            mask = vecs[k].msk ? bit_v : '0;
            req = bit_v;
            step();
            req = '0;
            step();
            step();
            step();
            check($sformatf("vec%0d_pending", k), 32'(pending), 32'(bit_v));
            check($sformatf("vec%0d_any", k), 32'(any_pending), 32'(vecs[k].exp_any));
            check($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(vecs[k].exp_valid));
            if (vecs[k].exp_valid)
                check($sformatf("vec%0d_code", k), 32'(out_code), 32'(vecs[k].idx));
            sw_clear = 1'b1;
            step();
            sw_clear = 1'b0;
            mask = '0;
            step();
            check($sformatf("vec%0d_clr_pending", k), 32'(pending), 32'd0);
            check($sformatf("vec%0d_clr_valid", k), 32'(out_valid), 32'd0);
        end

        // 1: req[5] for 3 cycles, exact latency
        out_ready = 1'b1;
        exp_q.push_back(4'd5);
        req = 16'h0020;
        step();             // E0
        step();             // E1
        step();             // E2
        req = '0;
        check("t1_pending_e2", 32'(pending), 32'h0020);
        check("t1_valid_e2", 32'(out_valid), 32'd0);
        step();             // E3
        check("t1_valid_e3", 32'(out_valid), 32'd1);
        check("t1_code_e3", 32'(out_code), 32'd5);
        step();             // E4, accepted
        check("t1_valid_after", 32'(out_valid), 32'd0);
        check("t1_pending_after", 32'(pending), 32'd0);
        check("t1_any_after", 32'(any_pending), 32'd0);
        check("t1_sb", 32'(exp_q.size()), 32'd0);
        step();

        // 2: req[3] and req[9] together
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd9);
        req = 16'h0208;
        step();
        req = '0;
        wait_drain(12, "t2_drain");
        check("t2_pending", 32'(pending), 32'd0);
        check("t2_valid", 32'(out_valid), 32'd0);
        step();

        // 3: offer of 9 held while req[2] arrives
        out_ready = 1'b0;
        req = 16'h0200;
        step();
        req = '0;
        wait_valid(6, "t3_valid9");
        check("t3_code9", 32'(out_code), 32'd9);
        req = 16'h0004;
        step();
        req = '0;
        step();
        step();
        step();
        check("t3_code_held", 32'(out_code), 32'd9);
        check("t3_valid_held", 32'(out_valid), 32'd1);
        check("t3_pending", 32'(pending), 32'h0204);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd2);
        out_ready = 1'b1;
        wait_drain(10, "t3_drain");
        check("t3_pending_after", 32'(pending), 32'd0);
        step();

        // 4: masked request released later
        mask = 16'h0080;
        req = 16'h0080;
        step();
        req = '0;
        step();
        step();
        step();
        step();
        check("t4_pending", 32'(pending), 32'h0080);
        check("t4_any", 32'(any_pending), 32'd0);
        check("t4_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(4'd7);
        mask = '0;
        wait_valid(2, "t4_valid_unmask");
        check("t4_code", 32'(out_code), 32'd7);
        wait_drain(4, "t4_drain");
        check("t4_pending_after", 32'(pending), 32'd0);
        step();

        // 5: new rise on req[4] lands on the accepting edge
        out_ready = 1'b0;
        req = 16'h0010;
        step();
        req = '0;
        wait_valid(6, "t5_valid");
        check("t5_code", 32'(out_code), 32'd4);
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd4);
        req = 16'h0010;
        step();             // E0
        req = '0;
        step();             // E1
        out_ready = 1'b1;
        step();             // E2: accept and set coincide
        check("t5_pending_kept", 32'(pending & 16'h0010), 32'h0010);
        check("t5_valid_drop", 32'(out_valid), 32'd0);
        wait_drain(6, "t5_drain");
        check("t5_pending_after", 32'(pending), 32'd0);
        step();

        // 6: reset in the middle of an offer of 12
        out_ready = 1'b0;
        mask = 16'h0010;
        req = 16'h1010;
        step();
        req = 16'h1000;
        wait_valid(6, "t6_valid");
        check("t6_code", 32'(out_code), 32'd12);
        check("t6_pending", 32'(pending), 32'h1010);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_pending", 32'(pending), 32'd0);
        step();
        step();
        check("t6_hold_pending", 32'(pending), 32'd0);
        check("t6_hold_valid", 32'(out_valid), 32'd0);
        req = '0;
        mask = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t6_post_pending", 32'(pending), 32'd0);
        check("t6_post_valid", 32'(out_valid), 32'd0);
        check("t6_post_any", 32'(any_pending), 32'd0);

        check("final_sb", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_irq_request_latch
